// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Owns every PC hold, IF/ID hold/flush and ID/EX bubble decision:
// load-use hazards, taken-branch flushes and multi-cycle op sequencing.
module pipeline_stall_controller #(
  parameter int unsigned MC_LATENCY = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EXE_MemRead,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic [4:0]       ID_EXE_rd,
  input  logic             ID_mc_op,
  input  logic             EX_branch_taken,
  output logic             PC_Write,
  output logic             IF_ID_REG_Write,
  output logic             IF_ID_flush,
  output logic             control_MUX_select,
  output logic             mc_start,
  output logic             mc_kill,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_count
);

  // Down-counter is at least one bit wide so MC_LATENCY=1 still gets one wait cycle.
  localparam int unsigned McCntW = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;
  localparam logic [McCntW-1:0] McLoad = McCntW'(MC_LATENCY - 1);
  localparam logic [CNT_W-1:0]  StallMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMcWait = 2'd1,
    StMcDone = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [McCntW-1:0]   r_mc_cnt;
  logic [McCntW-1:0]   w_mc_cnt_d;
  logic [CNT_W-1:0]    r_stall_count;

  logic w_lu;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_flush;
  logic w_mux_sel;
  logic w_start;
  logic w_kill;
  logic w_busy;

  // Load-use hazard: EX load writes a register that the ID instruction reads (x0 excluded).
  assign w_lu = ID_EXE_MemRead && (ID_EXE_rd != 5'd0) &&
                ((ID_EXE_rd == IF_ID_rs1) || (ID_EXE_rd == IF_ID_rs2));

  // Next-state and combinational control decode from current state and hazard inputs.
  always_comb begin
    w_state_d    = r_state;
    w_mc_cnt_d   = r_mc_cnt;
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_flush      = 1'b0;
    w_mux_sel    = 1'b0;
    w_start      = 1'b0;
    w_kill       = 1'b0;
    w_busy       = 1'b0;
    unique case (r_state)
      StRun: begin
        if (EX_branch_taken) begin
          // Branch wins over everything; wrong-path ID instruction is squashed.
          w_flush   = 1'b1;
          w_mux_sel = 1'b1;
        end else if (w_lu) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_mux_sel    = 1'b1;
        end else if (ID_mc_op) begin
          w_start      = 1'b1;
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_mux_sel    = 1'b1;
          w_mc_cnt_d   = McLoad;
          w_state_d    = StMcWait;
        end
      end
      StMcWait: begin
        if (EX_branch_taken) begin
          // The op in ID is on the wrong path: abort the unit and flush.
          w_kill    = 1'b1;
          w_flush   = 1'b1;
          w_mux_sel = 1'b1;
          w_state_d = StRun;
        end else begin
          w_busy       = 1'b1;
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_mux_sel    = 1'b1;
          if (r_mc_cnt == '0) begin
            w_state_d = StMcDone;
          end else begin
            w_mc_cnt_d = r_mc_cnt - McCntW'(1);
          end
        end
      end
      StMcDone: begin
        // One release cycle lets the op advance into EX; new hazards are not looked at here.
        if (EX_branch_taken) begin
          w_flush   = 1'b1;
          w_mux_sel = 1'b1;
        end
        w_state_d = StRun;
      end
      default: begin
        w_state_d = StRun;
      end
    endcase
  end

  // FSM state and multi-cycle down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StRun;
      r_mc_cnt <= '0;
    end else begin
      r_state  <= w_state_d;
      r_mc_cnt <= w_mc_cnt_d;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (!w_pc_write && (r_stall_count != StallMax)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  // Reset forces outputs to their idle values; the multi-cycle unit shares this reset,
  // so no kill pulse is needed.
  assign PC_Write           = reset | w_pc_write;
  assign IF_ID_REG_Write    = reset | w_ifid_write;
  assign IF_ID_flush        = ~reset & w_flush;
  assign control_MUX_select = ~reset & w_mux_sel;
  assign mc_start           = ~reset & w_start;
  assign mc_kill            = ~reset & w_kill;
  assign mc_busy            = ~reset & w_busy;
  assign stall_count        = r_stall_count;

endmodule
